// File: rtl/link_pkg.sv
// Shared definitions for the board-to-board game link (used by link_tx and link_rx).
// Frame: start(0), 8 data bits LSB first, even parity, stop(1).
package link_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} link_state_t;

  localparam int LINK_DATA_BITS  = 8;
  localparam int LINK_FRAME_BITS = 11;

  localparam int PWR_LSB   = 0;
  localparam int READY_BIT = 4;
  localparam int THROW_BIT = 5;
  localparam int SEQ_LSB   = 6;

  typedef struct packed {
    logic       throw_flag;
    logic       player_ready;
    logic [3:0] power;
  } link_fields_t;

  function automatic logic [LINK_DATA_BITS-1:0] link_payload(input logic [1:0] seq,
                                                              input link_fields_t f);
    logic [LINK_DATA_BITS-1:0] p;
    p                 = '0;
    p[SEQ_LSB +: 2]   = seq;
    p[THROW_BIT]      = f.throw_flag;
    p[READY_BIT]      = f.player_ready;
    p[PWR_LSB +: 4]   = f.power;
    return p;
  endfunction

endpackage

// File: rtl/link_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// Held at zero while clear is asserted so the first bit after clear is full length.
module link_baud_gen #(
  parameter int CLKS_PER_BIT = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_tick = !clear && (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (clear || bit_tick) cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/link_tx.sv
// Game-link serial transmitter: sends {seq, throw, ready, power} on change of the
// local fields and periodically as a keepalive. All outputs are registered.
module link_tx
  import link_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 60,
  parameter int REFRESH_CYCLES = 600000
) (
  input  logic       clk60MHz,
  input  logic       rst,
  input  logic       link_en,
  input  logic       player_ready,
  input  logic       throw_flag,
  input  logic [3:0] power,
  output logic       tx,
  output logic       busy,
  output logic       frame_sent,
  output logic [1:0] seq
);

  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_CYCLES - 1);

  link_state_t               state, state_nxt;
  logic [2:0]                bit_idx, idx_nxt, idx_plus;
  logic [LINK_DATA_BITS-1:0] shreg, payload;
  logic [RW-1:0]             refresh_cnt;
  link_fields_t              cur, last_sent;
  logic                      first_pending;
  logic [1:0]                seq_next;
  logic                      launch, bit_tick;
  logic                      tx_nxt, busy_nxt, sent_nxt;

  assign cur      = {throw_flag, player_ready, power};
  assign seq_next = seq + 2'd1;
  assign payload  = link_payload(seq_next, cur);
  assign idx_plus = bit_idx + 3'd1;

  link_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk60MHz),
    .rst      (rst),
    .clear    (state == IDLE),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = bit_idx;
    tx_nxt    = tx;
    busy_nxt  = busy;
    sent_nxt  = 1'b0;
    launch    = 1'b0;
    case (state)
      IDLE: begin
        launch = link_en && (first_pending || (cur != last_sent) || (refresh_cnt == REF_MAX));
        if (launch) begin
          state_nxt = START;
          idx_nxt   = '0;
          tx_nxt    = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      START: if (bit_tick) begin
        state_nxt = DATA;
        tx_nxt    = shreg[0];
      end
      DATA: if (bit_tick) begin
        if (bit_idx == 3'd7) begin
          state_nxt = PARITY;
          tx_nxt    = ^shreg;
        end else begin
          idx_nxt = idx_plus;
          tx_nxt  = shreg[idx_plus];
        end
      end
      PARITY: if (bit_tick) begin
        state_nxt = STOP;
        tx_nxt    = 1'b1;
      end
      STOP: if (bit_tick) begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        sent_nxt  = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk60MHz or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bit_idx       <= '0;
      tx            <= 1'b1;
      busy          <= 1'b0;
      frame_sent    <= 1'b0;
      seq           <= '0;
      shreg         <= '0;
      last_sent     <= '0;
      first_pending <= 1'b1;
      refresh_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      bit_idx    <= idx_nxt;
      tx         <= tx_nxt;
      busy       <= busy_nxt;
      frame_sent <= sent_nxt;
      if (launch) begin
        shreg         <= payload;
        seq           <= seq_next;
        last_sent     <= cur;
        first_pending <= 1'b0;
      end
      // Keepalive timer only runs while idle and enabled; it is zero for the whole frame.
      if (!link_en)
        refresh_cnt <= '0;
      else if (state == IDLE) begin
        if (launch)                      refresh_cnt <= '0;
        else if (refresh_cnt != REF_MAX) refresh_cnt <= refresh_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_link_tx.sv
// Directed bench for link_tx with CLKS_PER_BIT=4, REFRESH_CYCLES=100.
module tb_link_tx;

  logic       clk60MHz = 1'b0;
  logic       rst = 1'b1;
  logic       link_en = 1'b1;
  logic       player_ready = 1'b1;
  logic       throw_flag = 1'b0;
  logic [3:0] power = 4'hA;
  logic       tx, busy, frame_sent;
  logic [1:0] seq;

  int n_tests = 0;
  int n_fail  = 0;
  int n;

  link_tx #(.CLKS_PER_BIT(4), .REFRESH_CYCLES(100)) dut (
    .clk60MHz     (clk60MHz),
    .rst          (rst),
    .link_en      (link_en),
    .player_ready (player_ready),
    .throw_flag   (throw_flag),
    .power        (power),
    .tx           (tx),
    .busy         (busy),
    .frame_sent   (frame_sent),
    .seq          (seq)
  );

  always #5 clk60MHz = ~clk60MHz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Counts negedges until tx is low; -1 if it stays high for max cycles.
  task automatic wait_fall(input int max, output int cnt);
    cnt = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk60MHz);
      if (tx == 1'b0) begin
        cnt = i;
        break;
      end
    end
  endtask

  // Entered at the first negedge of the start bit; returns at the frame_sent cycle.
  task automatic check_frame(input string tag, input logic [7:0] data, input logic par,
                             input logic [1:0] exp_seq);
    logic [10:0] f;
    logic        b0, b43, b44, fs44;
    int          fs_cnt;
    f = '0; fs_cnt = 0; b0 = 0; b43 = 0; b44 = 0; fs44 = 0;
    for (int c = 0; c <= 44; c++) begin
      if (c > 0) @(negedge clk60MHz);
      if ((c % 4) == 2 && c < 44) f[c/4] = tx;
      if (frame_sent) fs_cnt++;
      if (c == 0)  b0 = busy;
      if (c == 43) b43 = busy;
      if (c == 44) begin
        b44  = busy;
        fs44 = frame_sent;
      end
    end
    chk({tag, "_bits"}, 32'(f), 32'({1'b1, par, data, 1'b0}));
    chk({tag, "_busy"}, 32'({b0, b43, b44}), 32'b110);
    chk({tag, "_fs"},   32'({fs44, fs_cnt == 1}), 32'b11);
    chk({tag, "_seq"},  32'(seq), 32'(exp_seq));
  endtask

  initial begin
    // Reset state
    @(negedge clk60MHz);
    @(negedge clk60MHz);
    chk("rst_tx",   32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fs",   32'(frame_sent), 32'd0);
    chk("rst_seq",  32'(seq), 32'd0);

    // First frame right after reset: 0x5A, parity 0
    rst = 1'b0;
    wait_fall(10, n);
    chk("f1_lat", 32'(n), 32'd1);
    check_frame("f1", 8'h5A, 1'b0, 2'd1);

    // Keepalive 100 idle cycles later: 0x9A, parity 0
    wait_fall(200, n);
    chk("ka_gap", 32'(n), 32'd100);
    check_frame("f2", 8'h9A, 1'b0, 2'd2);

    // power=3 launches; change to 7 mid-frame
    power = 4'h3;
    wait_fall(10, n);
    chk("f3_lat", 32'(n), 32'd1);
    fork
      check_frame("f3", 8'hD3, 1'b1, 2'd3);
      begin repeat (10) @(negedge clk60MHz); power = 4'h7; end
    join
    wait_fall(10, n);
    chk("f4_lat", 32'(n), 32'd1);
    check_frame("f4", 8'h17, 1'b0, 2'd0);

    // 3 -> 5 -> 3 glitch inside a frame: no follow-up frame
    power = 4'h3;
    wait_fall(10, n);
    chk("f5_lat", 32'(n), 32'd1);
    fork
      check_frame("f5", 8'h53, 1'b0, 2'd1);
      begin
        repeat (8) @(negedge clk60MHz);  power = 4'h5;
        repeat (12) @(negedge clk60MHz); power = 4'h3;
      end
    join
    wait_fall(50, n);
    chk("glitch_none", 32'(n), 32'hFFFF_FFFF);

    // link_en drops mid-frame: frame completes, then silence
    power = 4'h9;
    wait_fall(10, n);
    chk("f6_lat", 32'(n), 32'd1);
    fork
      check_frame("f6", 8'h99, 1'b0, 2'd2);
      begin repeat (12) @(negedge clk60MHz); link_en = 1'b0; end
    join
    wait_fall(500, n);
    chk("dis_silent", 32'(n), 32'hFFFF_FFFF);
    chk("dis_seq", 32'(seq), 32'd2);

    // Async reset during data bit 4 (frame 0xC2, bit4 = 0)
    link_en = 1'b1;
    player_ready = 1'b0;
    power = 4'h2;
    wait_fall(10, n);
    chk("f7_lat", 32'(n), 32'd1);
    repeat (21) @(negedge clk60MHz);
    chk("pre_rst_tx", 32'(tx), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("arst_vals", 32'({tx, busy, frame_sent, seq}), 32'b1_0_0_00);
    @(negedge clk60MHz);
    rst = 1'b0;
    wait_fall(10, n);
    chk("f8_lat", 32'(n), 32'd1);
    check_frame("f8", 8'h42, 1'b0, 2'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
